lsu_byte_sequencer: RTL

Multi-cycle load/store sequencer between the LSU request port and a byte-wide data memory bus.
- Loads: assembles byte, halfword or word data one byte per beat, then sign- or zero-extends it.
- Stores: serialises the store word into byte beats.
- One request in flight. Valid/ready handshake on the request and memory sides; single-cycle response pulse back to the pipeline.

---
 rtl/lsu_byte_sequencer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/lsu_byte_sequencer.sv
// Byte-serial load/store sequencer: one LSU request in flight, split into byte
// beats on the memory bus, with load data assembled and sign/zero-extended.
module lsu_byte_sequencer #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  typedef enum logic [1:0] {IDLE, BEAT, RESP} state_t;

  state_t              state_reg, state_next;
  logic                we_reg;
  logic [1:0]          size_reg;
  logic                uns_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [31:0]         wdata_reg;
  logic                err_reg;
  logic [1:0]          k_reg;
  logic [1:0]          n_last_reg;
  logic [31:0]         buf_reg;

  logic                accept;
  logic                req_err;
  logic                beat_done;
  logic                last_beat;
  logic [1:0]          req_n_last;
  logic [31:0]         load_ext;
  logic [7:0]          wdata_byte;

  assign accept    = req_valid && req_ready;
  assign beat_done = (state_reg == BEAT) && mem_ready;
  assign last_beat = (k_reg == n_last_reg);

  // Illegal size or misaligned half/word never reaches the memory bus.
  assign req_err = (req_size == 2'b11) ||
                   ((req_size == 2'b01) && req_addr[0]) ||
                   ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));

  always_comb begin
    req_n_last = 2'd0;
    case (req_size)
      2'b00:   req_n_last = 2'd0;
      2'b01:   req_n_last = 2'd1;
      default: req_n_last = 2'd3;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = req_err ? RESP : BEAT;
      BEAT:    if (beat_done && last_beat) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request latch, beat counter and load assembly buffer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_reg     <= 1'b0;
      size_reg   <= 2'b00;
      uns_reg    <= 1'b0;
      addr_reg   <= '0;
      wdata_reg  <= 32'd0;
      err_reg    <= 1'b0;
      k_reg      <= 2'd0;
      n_last_reg <= 2'd0;
      buf_reg    <= 32'd0;
    end else if (accept) begin
      we_reg     <= req_we;
      size_reg   <= req_size;
      uns_reg    <= req_unsigned;
      addr_reg   <= req_addr;
      wdata_reg  <= req_wdata;
      err_reg    <= req_err;
      k_reg      <= 2'd0;
      n_last_reg <= req_n_last;
      buf_reg    <= 32'd0;
    end else if (beat_done) begin
      k_reg <= k_reg + 2'd1;
      if (!we_reg) buf_reg[{k_reg, 3'b000} +: 8] <= mem_rdata;
    end
  end

  always_comb begin
    wdata_byte = wdata_reg[7:0];
    case (k_reg)
      2'd0: wdata_byte = wdata_reg[7:0];
      2'd1: wdata_byte = wdata_reg[15:8];
      2'd2: wdata_byte = wdata_reg[23:16];
      2'd3: wdata_byte = wdata_reg[31:24];
      default: wdata_byte = wdata_reg[7:0];
    endcase
  end

  always_comb begin
    load_ext = buf_reg;
    case (size_reg)
      2'b00:   load_ext = {{24{~uns_reg & buf_reg[7]}},  buf_reg[7:0]};
      2'b01:   load_ext = {{16{~uns_reg & buf_reg[15]}}, buf_reg[15:0]};
      default: load_ext = buf_reg;
    endcase
  end

  // Output logic: everything idles at zero outside its own state
  always_comb begin
    req_ready  = rst && (state_reg == IDLE);
    mem_valid  = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = 8'd0;
    resp_valid = 1'b0;
    resp_rdata = 32'd0;
    resp_err   = 1'b0;
    case (state_reg)
      BEAT: begin
        mem_valid = 1'b1;
        mem_we    = we_reg;
        mem_addr  = addr_reg + ADDR_W'(k_reg);
        mem_wdata = wdata_byte;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_reg;
        resp_rdata = (we_reg || err_reg) ? 32'd0 : load_ext;
      end
      default: ;
    endcase
  end

endmodule
